// File: rtl/seq_det_param.sv
// Multi-channel serial sequence detector: flags each LEN-bit PATTERN occurrence per channel.
// Optional saturating per-channel match counters are built with SEQ_DET_COUNT_EN defined.
module seq_det_param #(
    parameter int unsigned    LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = LEN'(4'b1011),
    parameter int unsigned    CH      = 2,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [CH-1:0]       x,
    input  logic                overlap,
    input  logic                clear,
    output logic [CH-1:0]       z,
    output logic                any_z
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CH*CNT_W-1:0] match_cnt
`endif
);

    localparam int unsigned    FW   = $clog2(LEN + 1);
    localparam logic [FW-1:0]  FULL = FW'(LEN);

    logic [LEN-1:0] r_hist [CH];
    logic [FW-1:0]  r_fill [CH];

    logic [LEN-1:0] w_nh        [CH];
    logic [FW-1:0]  w_nf        [CH];
    logic [CH-1:0]  w_m;
    logic [LEN-1:0] w_hist_nxt  [CH];
    logic [FW-1:0]  w_fill_nxt  [CH];
    logic [CH-1:0]  w_z_nxt;

    // Candidate history/fill after accepting this cycle's bit, and the match condition
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            w_nh[k] = {r_hist[k][LEN-2:0], x[k]};
            w_nf[k] = (r_fill[k] == FULL) ? FULL : r_fill[k] + FW'(1);
            w_m[k]  = (w_nf[k] == FULL) && (w_nh[k] == PATTERN);
        end
    end

    // Next-state: fill is the per-channel FSM state (FILL_k, HUNT when full)
    always_comb begin
        w_z_nxt = '0;
        for (int k = 0; k < CH; k++) begin
            w_hist_nxt[k] = r_hist[k];
            w_fill_nxt[k] = r_fill[k];
            if (clear) begin
                w_hist_nxt[k] = '0;
                w_fill_nxt[k] = '0;
            end else if (in_valid) begin
                w_z_nxt[k] = w_m[k];
                if (w_m[k] && !overlap) begin
                    w_hist_nxt[k] = '0;
                    w_fill_nxt[k] = '0;
                end else begin
                    w_hist_nxt[k] = w_nh[k];
                    w_fill_nxt[k] = w_nf[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CH; k++) begin
                r_hist[k] <= '0;
                r_fill[k] <= '0;
            end
            z     <= '0;
            any_z <= 1'b0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                r_hist[k] <= w_hist_nxt[k];
                r_fill[k] <= w_fill_nxt[k];
            end
            z     <= w_z_nxt;
            any_z <= |w_z_nxt;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_cnt     [CH];
    logic [CNT_W-1:0] w_cnt_nxt [CH];

    // Saturating match counters, flushed together with the history
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            w_cnt_nxt[k] = r_cnt[k];
            if (clear) begin
                w_cnt_nxt[k] = '0;
            end else if (in_valid && w_m[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
                w_cnt_nxt[k] = r_cnt[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CH; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_cnt_out
        assign match_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end
`endif

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised multi-channel serial sequence detector, the successor to the two-input fixed-pattern `fsm_10` detector. It watches `CH` independent serial bit streams and flags each occurrence of a compile-time `LEN`-bit pattern per channel. Overlapping or non-overlapping detection is selectable at run time, and optional per-channel saturating match counters can be built in. It sits between the serial stimulus/input stage and downstream event logic in the FSM assignment set.

## Interface
Parameters:
- `LEN`, default 4: pattern length in bits, 2..16.
- `PATTERN`, default 4'b1011: pattern bits; bit `LEN-1` is received first.
- `CH`, default 2: number of independent channels (ch0 is the x-stream, ch1 the y-stream of the previous block).
- `CNT_W`, default 8: match counter width; only used with `SEQ_DET_COUNT_EN`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: all channels sample `x` this cycle.
- `x`, input, CH: serial bit per channel.
- `overlap`, input, 1: 1 = overlapping detection, 0 = non-overlapping.
- `clear`, input, 1: synchronous flush of history, fill and counters.
- `z`, output, CH: per-channel one-cycle match pulse, registered.
- `any_z`, output, 1: OR of `z`, registered, coincident with `z`.
- `match_cnt`, output, CH*CNT_W: per-channel match counts; ch k is at `[k*CNT_W +: CNT_W]`. Present only with `SEQ_DET_COUNT_EN`.

## Operation
Per-channel state:
- `hist[LEN-1:0]`: shift register holding the last sampled bits.
- `fill`: 0..LEN, the number of valid bits in `hist`. It saturates at LEN and is the FSM state. State FILL_k means k bits are held; HUNT means fill = LEN.

On each rising edge, in priority order:
1. `rst` = 0, asynchronous: `hist`, `fill`, `z`, `any_z` and `match_cnt` all go to 0 immediately.
2. `clear` = 1: `hist` = 0, `fill` = 0, counters = 0, `z` = 0. `in_valid` is ignored this cycle.
3. `in_valid` = 1, per channel:
   - The channel computes `nh = {hist[LEN-2:0], x[k]}`, `nf = min(fill+1, LEN)`, and `m = (nf == LEN) && (nh == PATTERN)`.
   - `z[k]` <= `m`.
   - If `m` and `overlap` = 1: `hist` <= `nh`, `fill` <= LEN. A later match may reuse bits.
   - If `m` and `overlap` = 0: `hist` <= 0, `fill` <= 0. The next match needs LEN fresh bits.
   - Otherwise: `hist` <= `nh`, `fill` <= `nf`.
   - With counting built in, the channel's counter increments on `m` and saturates at 2^CNT_W−1.
4. `in_valid` = 0: `hist` and `fill` hold, and `z` <= 0.

Channels are fully independent. Simultaneous matches on several channels each pulse their own `z` bit.

The `overlap` input is sampled on the same edge as the bit it applies to. Changing it mid-stream takes effect from that sampled bit onward.

## Timing
- Latency: `z[k]` rises on the edge after the edge that samples the completing bit. Equivalently, it is high during the cycle following the completing bit's input cycle.
- `z` lasts exactly one cycle per match. Back-to-back matches, which are possible only with overlap and a self-overlapping pattern, give consecutive pulses.
- Reset values: `z` = 0, `any_z` = 0, `match_cnt` = 0.
- There is no back-pressure, and throughput is one bit per channel per cycle.

## Configuration
- `SEQ_DET_COUNT_EN` defined: `match_cnt` port and CH × CNT_W saturating counters are present. They are cleared by `rst` and `clear`.
- Not defined: the port, the counters and all their logic are absent. Detection and `z` behaviour are identical in both builds.

## Test plan
All scenarios use LEN = 4, PATTERN = 4'b1011, CH = 2 and CNT_W = 8.
- Reset: hold `rst` = 0 for 2 cycles mid-stream with `x` toggling → `z` = 0, `any_z` = 0, `match_cnt` = 0 immediately; no pulse after release until 4 new bits arrive.
- Basic: ch0 is fed 1,0,1,1 and ch1 is fed 0,0,0,0, with `in_valid` = 1 → `z` = 2'b01 and `any_z` = 1 for exactly one cycle, in the cycle after the 4th bit.
- Overlap mode: ch0 is fed 1,0,1,1,0,1,1.
  - With `overlap` = 1: pulses after bit 4 and after bit 7, and `match_cnt[7:0]` = 2.
  - With `overlap` = 0: one pulse, after bit 4 only.
- Valid gaps: ch0 is fed 1,0, then 3 cycles with `in_valid` = 0 and `x` = 0, then 1,1 → exactly one `z[0]` pulse, after the final bit.
- Clear: ch0 is fed 1,0,1, then `clear` = 1 with `x` = 1 and `in_valid` = 1, then 1 → no pulse, and `match_cnt` = 0.
- Saturation (`SEQ_DET_COUNT_EN` defined, `overlap` = 1): ch1 receives repeating 1011 for 300 matches → `match_cnt[15:8]` = 255 and stays there; ch0 count is unaffected.
